// File: rtl/arith_sched_if.sv
// rtl/arith_sched_if.sv - request/result handshake bundle for arith_sched
interface arith_sched_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [39:0] req0_opnd;
  logic [1:0]  req0_mode;
  logic        req1_valid;
  logic        req1_ready;
  logic [39:0] req1_opnd;
  logic [1:0]  req1_mode;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_id;

  modport master (
    output req0_valid, req0_opnd, req0_mode,
    input  req0_ready,
    output req1_valid, req1_opnd, req1_mode,
    input  req1_ready,
    input  res_valid, res_data, res_id,
    output res_ready
  );

  modport slave (
    input  req0_valid, req0_opnd, req0_mode,
    output req0_ready,
    input  req1_valid, req1_opnd, req1_mode,
    output req1_ready,
    output res_valid, res_data, res_id,
    input  res_ready
  );
endinterface

// File: rtl/arith_sched.sv
// rtl/arith_sched.sv - two-requester round-robin arithmetic unit with fixed latency
module arith_sched #(
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  arith_sched_if.slave bus,
  output logic         busy,
  output logic [7:0]   done_cnt
);

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t      state, state_nxt;
  logic        last;
  logic [3:0]  cnt;
  logic [39:0] op_q;
  logic [1:0]  mode_q;
  logic        id_q;
  logic        grant;
  logic        accept;
  logic        calc_done;
  logic        handoff;

  // All intermediates are deliberately truncated to 16 bits.
  function automatic logic [15:0] calc(input logic [39:0] op, input logic [1:0] md);
    logic [15:0] a, b, c, d, e, m1, m2, m3, m4;
    a  = {8'h00, op[39:32]};
    b  = {8'h00, op[31:24]};
    c  = {8'h00, op[23:16]};
    d  = {8'h00, op[15:8]};
    e  = {8'h00, op[7:0]};
    m1 = (a + b) * (c + d);
    m2 = a * c + b * d;
    m3 = ((a ^ b) + d) * (e & 16'h000F);
    m4 = (m1 + m2) ^ (m3 >> 2);
    case (md)
      2'd0:    calc = m1;
      2'd1:    calc = m2;
      2'd2:    calc = m3;
      default: calc = m4;
    endcase
  endfunction

  always_comb begin
    state_nxt      = state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    accept         = 1'b0;
    calc_done      = 1'b0;
    handoff        = 1'b0;
    // On a tie the requester that was not served last wins.
    if (bus.req0_valid && bus.req1_valid) grant = ~last;
    else                                  grant = bus.req1_valid;
    case (state)
      IDLE: begin
        bus.req0_ready = !rst && bus.req0_valid && !grant;
        bus.req1_ready = !rst && bus.req1_valid && grant;
        accept         = bus.req0_ready || bus.req1_ready;
        if (accept) state_nxt = CALC;
      end
      CALC: begin
        if (cnt == 4'(LAT - 1)) begin
          calc_done = 1'b1;
          state_nxt = OUT;
        end
      end
      OUT: begin
        if (bus.res_valid && bus.res_ready) begin
          handoff   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last          <= 1'b1;
      cnt           <= 4'd0;
      op_q          <= 40'd0;
      mode_q        <= 2'd0;
      id_q          <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= 16'd0;
      bus.res_id    <= 1'b0;
      done_cnt      <= 8'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q   <= grant ? bus.req1_opnd : bus.req0_opnd;
        mode_q <= grant ? bus.req1_mode : bus.req0_mode;
        id_q   <= grant;
        last   <= grant;
        cnt    <= 4'd0;
      end else if (state == CALC) begin
        cnt <= cnt + 4'd1;
      end
      if (calc_done) begin
        bus.res_valid <= 1'b1;
        bus.res_data  <= calc(op_q, mode_q);
        bus.res_id    <= id_q;
      end
      if (handoff) begin
        bus.res_valid <= 1'b0;
        done_cnt      <= done_cnt + 8'd1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_arith_sched.sv
// tb/tb_arith_sched.sv - directed self-checking bench for arith_sched
module tb_arith_sched;
  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [7:0] done_cnt;
  int         cyc = 0;
  int         vecs = 0;
  int         miscompares = 0;

  logic [39:0] sweep_op = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
  logic [15:0] sweep_exp [4] = '{16'd21, 16'd11, 16'd35, 16'd40};

  arith_sched_if bus ();

  arith_sched #(.LAT(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .busy     (busy),
    .done_cnt (done_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic r, input logic [39:0] op, input logic [1:0] md,
                       input logic [15:0] exp, input string tag);
    int t_acc;
    int n;
    @(negedge clk);
    bus.res_ready = 1'b1;
    if (r) begin
      bus.req1_valid = 1'b1; bus.req1_opnd = op; bus.req1_mode = md;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_opnd = op; bus.req0_mode = md;
    end
    n = 0;
    #1;
    while (!(r ? bus.req1_ready : bus.req0_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, "_accept"}, 32'(n < 20), 32'd1);
    t_acc = cyc;
    @(negedge clk);
    // Scramble the inputs right after acceptance; the result must not change.
    if (r) begin
      bus.req1_valid = 1'b0; bus.req1_opnd = ~op; bus.req1_mode = ~md;
    end else begin
      bus.req0_valid = 1'b0; bus.req0_opnd = ~op; bus.req0_mode = ~md;
    end
    n = 0;
    #1;
    while (!bus.res_valid && n < 40) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, "_lat"},  32'(cyc - t_acc), 32'(LAT + 1));
    chk({tag, "_data"}, 32'(bus.res_data), 32'(exp));
    chk({tag, "_id"},   32'(bus.res_id), 32'(r));
  endtask

  initial begin
    int n;
    logic exp_id;
    logic [15:0] snap_data;

    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_opnd = 40'd0; bus.req0_mode = 2'd0;
    bus.req1_valid = 1'b1; bus.req1_opnd = 40'd0; bus.req1_mode = 2'd0;
    bus.res_ready  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready0",   32'(bus.req0_ready), 32'd0);
    chk("rst_ready1",   32'(bus.req1_ready), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data", 32'(bus.res_data), 32'd0);
    chk("rst_res_id",   32'(bus.res_id), 32'd0);
    chk("rst_busy",     32'(busy), 32'd0);
    chk("rst_done_cnt", 32'(done_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Mode sweep on requester 0.
    do_op(1'b0, sweep_op, 2'd0, 16'd21, "sweep_m0");
    do_op(1'b0, sweep_op, 2'd1, 16'd11, "sweep_m1");
    do_op(1'b0, sweep_op, 2'd2, 16'd35, "sweep_m2");
    do_op(1'b0, sweep_op, 2'd3, 16'd40, "sweep_m3");
    @(negedge clk); #1;
    chk("sweep_done_cnt", 32'(done_cnt), 32'd4);

    // 16-bit wrap cases.
    do_op(1'b0, 40'hFF_FF_FF_FF_00, 2'd0, 16'hF804, "wrap_m1");
    do_op(1'b0, 40'hFF_FF_FF_FF_00, 2'd3, 16'hF406, "wrap_m4");
    do_op(1'b1, 40'hF0_0F_00_20_FF, 2'd2, 16'h10D1, "mask_m3");

    // Arbitration from reset with both requesters held valid.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    bus.res_ready  = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_opnd = sweep_op;             bus.req0_mode = 2'd1;
    bus.req1_valid = 1'b1; bus.req1_opnd = 40'h02_03_04_05_06;   bus.req1_mode = 2'd0;
    for (int k = 0; k < 4; k++) begin
      exp_id = k[0];
      n = 0;
      #1;
      while (!(bus.req0_ready || bus.req1_ready) && n < 20) begin
        @(negedge clk); #1; n++;
      end
      chk("arb_ready0", 32'(bus.req0_ready), 32'(!exp_id));
      chk("arb_ready1", 32'(bus.req1_ready), 32'(exp_id));
      n = 0;
      @(negedge clk); #1;
      while (!bus.res_valid && n < 20) begin
        @(negedge clk); #1; n++;
      end
      chk("arb_res_id",   32'(bus.res_id), 32'(exp_id));
      chk("arb_res_data", 32'(bus.res_data), exp_id ? 32'd45 : 32'd11);
      @(negedge clk);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Backpressure in OUT.
    @(negedge clk);
    bus.res_ready  = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_opnd = sweep_op; bus.req0_mode = 2'd2;
    #1;
    chk("bp_accept", 32'(bus.req0_ready), 32'd1);
    @(negedge clk);
    bus.req1_valid = 1'b1;
    n = 0;
    #1;
    while (!bus.res_valid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    snap_data = bus.res_data;
    chk("bp_first_data", 32'(snap_data), 32'd35);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid",  32'(bus.res_valid), 32'd1);
      chk("bp_data",   32'(bus.res_data), 32'(snap_data));
      chk("bp_id",     32'(bus.res_id), 32'd0);
      chk("bp_ready0", 32'(bus.req0_ready), 32'd0);
      chk("bp_ready1", 32'(bus.req1_ready), 32'd0);
      chk("bp_cnt",    32'(done_cnt), 32'd4);
      @(negedge clk); #1;
    end
    bus.res_ready = 1'b1;
    #1;
    chk("handoff_ready0", 32'(bus.req0_ready), 32'd0);
    chk("handoff_ready1", 32'(bus.req1_ready), 32'd0);
    @(negedge clk); #1;
    chk("post_valid", 32'(bus.res_valid), 32'd0);
    chk("post_busy",  32'(busy), 32'd0);
    chk("post_cnt",   32'(done_cnt), 32'd5);
    chk("post_ready1", 32'(bus.req1_ready), 32'd1);
    chk("post_ready0", 32'(bus.req0_ready), 32'd0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Reset while an operation is in CALC.
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_opnd = sweep_op; bus.req0_mode = 2'd3;
    #1;
    chk("midrst_accept", 32'(bus.req0_ready), 32'd1);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    #1;
    chk("midrst_busy_calc", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy",  32'(busy), 32'd0);
    chk("midrst_valid", 32'(bus.res_valid), 32'd0);
    chk("midrst_cnt",   32'(done_cnt), 32'd0);
    repeat (LAT + 2) begin
      @(negedge clk); #1;
      chk("midrst_no_result", 32'(bus.res_valid), 32'd0);
    end
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    chk("midrst_tie_ready0", 32'(bus.req0_ready), 32'd1);
    chk("midrst_tie_ready1", 32'(bus.req1_ready), 32'd0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk); #1;
    chk("withdraw_busy", 32'(busy), 32'd0);

    // done_cnt wrap after 256 completed operations.
    for (int i = 0; i < 255; i++) begin
      do_op(1'b0, sweep_op, 2'(i), sweep_exp[i % 4], "cntwrap");
    end
    @(negedge clk); #1;
    chk("cnt_255", 32'(done_cnt), 32'd255);
    do_op(1'b0, sweep_op, 2'd3, 16'd40, "cntwrap_last");
    @(negedge clk); #1;
    chk("cnt_wrap", 32'(done_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule

// File: doc/arith_sched.md
ARITH_SCHED -- requirements
Module: arith_sched

Interface
REQ-001 SHALL have parameter LAT, default 2, giving compute cycles per operation; legal range 1..15.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req0_valid  input  1  requester 0 has an operation pending.
REQ-005 SHALL have port req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 SHALL have port req0_opnd  input  40  {a,b,c,d,e}, 8 bits each, a in [39:32].
REQ-007 SHALL have port req0_mode  input  2  operation select for requester 0.
REQ-008 SHALL have ports req1_valid, req1_ready, req1_opnd, req1_mode, identical to REQ-004..007 for requester 1.
REQ-009 SHALL have port res_valid  output  1  result available.
REQ-010 SHALL have port res_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port res_data  output  16  result value.
REQ-012 SHALL have port res_id  output  1  index of the requester that issued the result.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port done_cnt  output  8  count of results handed off, wrapping 255->0.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, OUT.
REQ-016 In IDLE, reqN_ready SHALL be 1 only for the granted requester, and only when that requester is valid; both readys are 0 in CALC and OUT.
REQ-017 Grant SHALL be round-robin: with one requester valid, grant it; with both valid, grant the one not served last; the last-served pointer SHALL reset to 1, so requester 0 wins the first tie.
REQ-018 On accept (valid & ready in IDLE), operands, mode and id SHALL be latched, the last-served pointer SHALL be updated, and the FSM SHALL move to CALC.
REQ-019 CALC SHALL last exactly LAT cycles, then move to OUT with res_data, res_id and res_valid=1 registered.
REQ-020 Latency: accept in cycle T SHALL give res_valid=1 in cycle T+LAT+1.
REQ-021 In OUT, res_valid, res_data and res_id SHALL stay stable until res_valid & res_ready; then the FSM SHALL go to IDLE next cycle, res_valid SHALL drop, and done_cnt SHALL increment.
REQ-022 A new request SHALL NOT be accepted in the cycle the result is handed off; the next accept is no earlier than the first IDLE cycle.
REQ-023 Arithmetic SHALL use 16-bit unsigned modulo 2^16 for all intermediates, with no overflow flag:
- m1=(a+b)*(c+d)
- m2=a*c+b*d
- m3=((a^b)+d)*(e&0x0F)
- m4=(m1+m2)^(m3>>2)
REQ-024 res_data SHALL be m1, m2, m3 or m4 for latched mode 00, 01, 10 or 11 respectively.
REQ-025 Changes to reqN inputs after acceptance SHALL NOT affect the in-flight result.
REQ-026 A requester deasserting valid before it is granted SHALL lose nothing; no accept is recorded for it.

Reset
REQ-027 While rst=1, the following SHALL hold at the next edge: state=IDLE, res_valid=0, res_data=0, res_id=0, req0_ready=0, req1_ready=0, busy=0, done_cnt=0, last-served pointer=1.
REQ-028 Reset asserted in CALC or OUT SHALL discard the in-flight operation without producing a result, and done_cnt SHALL NOT increment.
REQ-029 Reset SHALL take priority over every simultaneous event, including accept and handoff.

Verification
REQ-030 Mode sweep, LAT=2: requester 0 sends opnd a=1,b=2,c=3,d=4,e=5 in modes 0..3 -> res_data 21, 11, 35, 40 respectively; res_id=0; each res_valid arrives 3 cycles after its accept.
REQ-031 Wrap case: a=b=c=d=255, e=0, mode 0 -> res_data=0xF804.
REQ-032 Arbitration: both requesters held valid after reset -> accept order 0,1,0,1; res_id follows that order.
REQ-033 Backpressure: res_ready held 0 for 5 cycles in OUT -> res_data and res_id stable, both readys 0, done_cnt unchanged; res_ready=1 -> done_cnt+1 and IDLE next cycle.
REQ-034 Reset mid-CALC -> res_valid stays 0, busy=0 next cycle, done_cnt=0, and the next tie is granted to requester 0.
REQ-035 Counter wrap: 256 completed operations -> done_cnt returns to 0.
